// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
// Defines the FSM state encoding, the slave register addresses and the default expected values.
package kernel_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_TS  = 3'd2,
        RETRY  = 3'd3,
        FINISH = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic        SYSID_ADDR_ID          = 1'b0;
    localparam logic        SYSID_ADDR_TS          = 1'b1;
    localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'd2;
    localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'd1504053489;
    localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd255;
    localparam logic [1:0]  DEFAULT_RETRY_LIMIT    = 2'd2;
    localparam int          TIMER_WIDTH            = 16;

    // A RETRY gap counts as part of the check even though no read is on the bus.
    function automatic logic is_busy_state(input state_t s);
        return (s == RD_ID) || (s == RD_TS) || (s == RETRY);
    endfunction

endpackage

// File: rtl/kernel_sysid_wait_timer.sv
// Counts stalled read cycles; flags the last permitted stall cycle of one attempt.
// Clear has priority over enable so an accept or state change always restarts the count.
module kernel_sysid_wait_timer #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = 16'd255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LAST = LIMIT - WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/kernel_sysid_checker.sv
// Avalon-MM read master that checks the sysid slave (ID then timestamp) at boot.
// Reports pass/fail per register plus a sticky timeout when a read exhausts its retries.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TS,
    parameter logic [15:0] TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [1:0]  RETRY_LIMIT        = DEFAULT_RETRY_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_retry_addr;
    logic [1:0]  r_retry_cnt;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout_err;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic w_accept;
    logic w_timer_expired;
    logic w_expire;
    logic w_give_up;
    logic w_start_ok;
    logic w_timer_clear;

    // Bus outputs decode straight from state so a reset drops the read strobe at once.
    assign avm_read    = (r_state == RD_ID) || (r_state == RD_TS);
    assign avm_address = (r_state == RD_TS) ? SYSID_ADDR_TS :
                         (r_state == RETRY) ? r_retry_addr  : SYSID_ADDR_ID;

    assign w_accept   = avm_read && !avm_waitrequest;
    assign w_expire   = avm_read && avm_waitrequest && w_timer_expired;
    assign w_give_up  = w_expire && (r_retry_cnt == RETRY_LIMIT);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    assign w_timer_clear = (w_next_state != r_state) || w_accept;

    kernel_sysid_wait_timer #(
        .WIDTH (TIMER_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (avm_read && avm_waitrequest),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assigned first so every path through the case drives
    // w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (w_start_ok) w_next_state = RD_ID;
            RD_ID: begin
                if (w_accept)       w_next_state = RD_TS;
                else if (w_give_up) w_next_state = FINISH;
                else if (w_expire)  w_next_state = RETRY;
            end
            RD_TS: begin
                if (w_accept || w_give_up) w_next_state = FINISH;
                else if (w_expire)         w_next_state = RETRY;
            end
            RETRY:   w_next_state = (r_retry_addr == SYSID_ADDR_TS) ? RD_TS : RD_ID;
            FINISH:  w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retry_addr  <= SYSID_ADDR_ID;
            r_retry_cnt   <= '0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            if (w_start_ok) begin
                r_id_ok       <= 1'b0;
                r_ts_ok       <= 1'b0;
                r_timeout_err <= 1'b0;
                r_retry_cnt   <= '0;
            end
            if (w_accept) begin
                r_retry_cnt <= '0;
                if (r_state == RD_ID) begin
                    r_id_value <= avm_readdata;
                    r_id_ok    <= (avm_readdata == EXPECTED_ID);
                end else begin
                    r_ts_value <= avm_readdata;
                    r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
                end
            end
            if (w_give_up) begin
                r_timeout_err <= 1'b1;
            end else if (w_expire) begin
                r_retry_cnt  <= r_retry_cnt + 2'd1;
                r_retry_addr <= avm_address;
            end
        end
    end

    assign busy        = is_busy_state(r_state);
    assign done        = (r_state == FINISH);
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
